// File: rtl/sbox_share_scheduler.sv
// Time-shares N_LANES AES S-box cells between a 128-bit SubBytes requester (multi-beat)
// and a 32-bit SubWord requester (single beat), key-first with alternation on contention.

module s_box_lookup (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Byte 0x00 sits in the top byte of the table.
  localparam logic [2047:0] Table = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = Table[{~data_i, 3'b000} +: 8];

endmodule

module sbox_share_scheduler #(
  parameter int unsigned N_LANES = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         blk_req,
  input  logic [127:0] blk_in,
  output logic         blk_done,
  output logic [127:0] blk_out,
  input  logic         key_req,
  input  logic [31:0]  key_in,
  output logic         key_done,
  output logic [31:0]  key_out,
  output logic         busy
);

  localparam int unsigned BEATS = 16 / N_LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW    = 8 * N_LANES;
  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StKey  = 2'd1;
  localparam logic [1:0] StBlk  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          last_key_q, last_key_d;
  logic [127:0]  blk_cap_q, blk_cap_d;
  logic [31:0]   key_cap_q, key_cap_d;
  logic [127:0]  blk_out_q, blk_out_d;
  logic [31:0]   key_out_q, key_out_d;
  logic          blk_done_q, blk_done_d;
  logic          key_done_q, key_done_d;
  logic          busy_q, busy_d;

  logic [127:0]  lane_src;
  logic [127:0]  res_bus;
  logic [127:0]  res_mask;
  logic [31:0]   sub_word;
  logic [7:0]    lane_in  [N_LANES];
  logic [7:0]    lane_out [N_LANES];

  // The current beat's bytes are shifted to the top so lane i always takes byte i of the window.
  always_comb begin
    lane_src = (state_q == StKey) ? {key_cap_q, 96'h0} : (blk_cap_q << (LW * beat_q));
    for (int i = 0; i < int'(N_LANES); i++) begin
      lane_in[i] = lane_src[127 - 8 * i -: 8];
    end
  end

  for (genvar g = 0; g < int'(N_LANES); g++) begin : g_lane
    s_box_lookup u_sbox (
      .data_i (lane_in[g]),
      .data_o (lane_out[g])
    );
  end

  // Lane results shifted back down to the bit positions they came from.
  always_comb begin
    res_bus = '0;
    for (int i = 0; i < int'(N_LANES); i++) begin
      res_bus[127 - 8 * i -: 8] = lane_out[i];
    end
    res_bus  = res_bus >> (LW * beat_q);
    res_mask = ({128{1'b1}} << (128 - LW)) >> (LW * beat_q);
    sub_word = {lane_out[0], lane_out[1], lane_out[2], lane_out[3]};
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_key_d = last_key_q;
    blk_cap_d  = blk_cap_q;
    key_cap_d  = key_cap_q;
    blk_out_d  = blk_out_q;
    key_out_d  = key_out_q;
    blk_done_d = 1'b0;
    key_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        // Key wins a tie unless it also won the previous grant.
        if (key_req && (!blk_req || !last_key_q)) begin
          state_d    = StKey;
          key_cap_d  = key_in;
          last_key_d = 1'b1;
        end else if (blk_req) begin
          state_d    = StBlk;
          blk_cap_d  = blk_in;
          beat_d     = '0;
          last_key_d = 1'b0;
        end
      end
      StKey: begin
        key_out_d  = sub_word;
        key_done_d = 1'b1;
        state_d    = StDone;
      end
      StBlk: begin
        blk_out_d = (blk_out_q & ~res_mask) | res_bus;
        if (beat_q == LastBeat) begin
          state_d    = StDone;
          beat_d     = '0;
          blk_done_d = 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      last_key_q <= 1'b0;
      blk_cap_q  <= '0;
      key_cap_q  <= '0;
      blk_out_q  <= '0;
      key_out_q  <= '0;
      blk_done_q <= 1'b0;
      key_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_key_q <= last_key_d;
      blk_cap_q  <= blk_cap_d;
      key_cap_q  <= key_cap_d;
      blk_out_q  <= blk_out_d;
      key_out_q  <= key_out_d;
      blk_done_q <= blk_done_d;
      key_done_q <= key_done_d;
      busy_q     <= busy_d;
    end
  end

  assign blk_out  = blk_out_q;
  assign key_out  = key_out_q;
  assign blk_done = blk_done_q;
  assign key_done = key_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sbox_share_scheduler.sv
// Bench for sbox_share_scheduler: directed scenarios plus random two-requester traffic,
// checked against a transaction-level model with an S-box derived from GF(2^8) arithmetic.

module tb_sbox_share_scheduler;

  parameter int unsigned N_LANES = 4;
  localparam int BEATS = 16 / N_LANES;

  logic         clk;
  logic         n_rst;
  logic         blk_req;
  logic [127:0] blk_in;
  logic         blk_done;
  logic [127:0] blk_out;
  logic         key_req;
  logic [31:0]  key_in;
  logic         key_done;
  logic [31:0]  key_out;
  logic         busy;

  sbox_share_scheduler #(.N_LANES(N_LANES)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .blk_req  (blk_req),
    .blk_in   (blk_in),
    .blk_done (blk_done),
    .blk_out  (blk_out),
    .key_req  (key_req),
    .key_in   (key_in),
    .key_done (key_done),
    .key_out  (key_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb [256];

  // Model: phase 0 idle, 1 working, 2 done; m_left counts edges until done.
  int           m_phase;
  int           m_left;
  bit           m_key_owner;
  bit           m_last_key;
  logic [127:0] m_blk_out, m_blk_res;
  logic [31:0]  m_key_out, m_key_res;
  bit           e_blk_done, e_key_done;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] subbytes(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8 * i +: 8] = sb[x[8 * i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8 * i +: 8] = sb[x[8 * i +: 8]];
    return r;
  endfunction

  task automatic model_edge();
    e_blk_done = 1'b0;
    e_key_done = 1'b0;
    if (m_phase == 0) begin
      if (key_req && (!blk_req || !m_last_key)) begin
        m_phase     = 1;
        m_left      = 1;
        m_key_owner = 1'b1;
        m_last_key  = 1'b1;
        m_key_res   = subword(key_in);
      end else if (blk_req) begin
        m_phase     = 1;
        m_left      = BEATS;
        m_key_owner = 1'b0;
        m_last_key  = 1'b0;
        m_blk_res   = subbytes(blk_in);
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_phase = 2;
        if (m_key_owner) begin
          e_key_done = 1'b1;
          m_key_out  = m_key_res;
        end else begin
          e_blk_done = 1'b1;
          m_blk_out  = m_blk_res;
        end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("busy", busy, m_phase != 0);
    check_eq("blk_done", blk_done, e_blk_done);
    check_eq("key_done", key_done, e_key_done);
    check_eq("key_out", key_out, m_key_out);
    // blk_out is only partially written while a block is in flight.
    if (!(m_phase == 1 && !m_key_owner)) check_eq("blk_out", blk_out, m_blk_out);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_blk_done", blk_done, 0);
    check_eq("rst_key_done", key_done, 0);
    check_eq("rst_blk_out", blk_out, 0);
    check_eq("rst_key_out", key_out, 0);
    m_phase    = 0;
    m_left     = 0;
    m_last_key = 1'b0;
    m_blk_out  = '0;
    m_key_out  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_done", {blk_done, key_done, busy}, 0);
    n_rst = 1'b1;
  endtask

  task automatic run_until_done(input bit want_key, output int lat);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      step();
      if ((want_key ? key_done : blk_done) === 1'b1) lat = i;
    end
    if (lat == 0) check_eq(want_key ? "key_timeout" : "blk_timeout", 0, 1);
  endtask

  initial begin
    int           lat;
    int           klat;
    logic         obs [$];
    logic [127:0] all63;
    logic [127:0] vec_out;

    n_rst   = 1'b0;
    blk_req = 1'b0;
    key_req = 1'b0;
    blk_in  = '0;
    key_in  = '0;
    all63   = {16{8'h63}};
    vec_out = 128'hd42711aee0bf98f1b8b45de51e415230;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sb[x] = affine(inv);
    end

    #3;
    do_reset();

    // Scenario 1: FIPS-197 SubBytes vector.
    blk_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    blk_req = 1'b1;
    run_until_done(1'b0, lat);
    blk_req = 1'b0;
    check_eq("s1_latency", lat, BEATS + 1);
    check_eq("s1_blk_out", blk_out, vec_out);
    step();
    check_eq("s1_done_pulse", blk_done, 0);

    // Scenario 2: SubWord vector; block result must survive.
    key_in  = 32'hcf4f3c09;
    key_req = 1'b1;
    run_until_done(1'b1, lat);
    key_req = 1'b0;
    check_eq("s2_latency", lat, 2);
    check_eq("s2_key_out", key_out, 32'h8a84eb01);
    check_eq("s2_blk_kept", blk_out, vec_out);
    step();

    // Scenario 3: simultaneous, continuously held requests alternate starting with key.
    do_reset();
    blk_in  = {$urandom, $urandom, $urandom, $urandom};
    key_in  = $urandom;
    blk_req = 1'b1;
    key_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (key_done) obs.push_back(1'b1);
      if (blk_done) obs.push_back(1'b0);
    end
    blk_req = 1'b0;
    key_req = 1'b0;
    check_eq("s3_grants", obs.size() >= 4, 1);
    while (obs.size() < 4) obs.push_back(1'bx);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("s3_grant%0d", i), obs[i], (i % 2) == 0);
    end
    repeat (8) step();

    // Scenario 4: key request arriving mid-block waits for the block to finish.
    blk_in  = {$urandom, $urandom, $urandom, $urandom};
    key_in  = $urandom;
    blk_req = 1'b1;
    lat     = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step();
      if (blk_done) begin
        lat     = k;
        blk_req = 1'b0;
      end
      if (k == 2) key_req = 1'b1;
      blk_in = {$urandom, $urandom, $urandom, $urandom};
    end
    check_eq("s4_blk_latency", lat, BEATS + 1);
    run_until_done(1'b1, klat);
    key_req = 1'b0;
    check_eq("s4_key_after_blk", klat, 3);
    step();

    // Scenario 5: reset in the middle of a block abandons it.
    blk_in  = {$urandom, $urandom, $urandom, $urandom};
    blk_req = 1'b1;
    repeat (3) step();
    blk_req = 1'b0;
    do_reset();
    blk_in  = '0;
    blk_req = 1'b1;
    run_until_done(1'b0, lat);
    blk_req = 1'b0;
    check_eq("s5_latency", lat, BEATS + 1);
    check_eq("s5_zero_block", blk_out, all63);
    step();

    // Random traffic: requesters hold until done, sometimes re-request at once.
    for (int c = 0; c < 600; c++) begin
      step();
      if (blk_done) blk_req = ($urandom_range(3) == 0);
      else if (!blk_req) blk_req = ($urandom_range(2) == 0);
      if (key_done) key_req = ($urandom_range(3) == 0);
      else if (!key_req) key_req = ($urandom_range(2) == 0);
      blk_in = {$urandom, $urandom, $urandom, $urandom};
      key_in = $urandom;
    end
    blk_req = 1'b0;
    key_req = 1'b0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
